// File: rtl/lpf_decimator_if.sv
// Sample stream into and averaged stream out of the lpf decimator.
// The slave modport is the decimator's view; master is the lpf/consumer side.
interface lpf_decimator_if #(
  parameter int DATA_W = 32
);
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              overrun;

  modport slave  (input  in_data, in_valid, out_ready,
                  output out_data, out_valid, overrun);
  modport master (output in_data, in_valid, out_ready,
                  input  out_data, out_valid, overrun);
endinterface

// File: rtl/lpf_decimator.sv
// Block-average decimator: sums 2^LOG2_DECIM samples, emits the mean via a 2-entry FIFO.
// Optional macro LPF_DECIM_ROUND_EN selects round-half-up instead of truncation.
module lpf_decimator #(
  parameter int DATA_W     = 32,
  parameter int LOG2_DECIM = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clr,
  lpf_decimator_if.slave  bus
);
  localparam int ACC_W = DATA_W + LOG2_DECIM;

  logic [ACC_W-1:0]           acc, sum, sum_r;
  logic [LOG2_DECIM-1:0]      phase;
  logic                       last, push, pop, full, do_push;
  logic [DATA_W-1:0]          avg;
  logic [1:0][DATA_W-1:0]     mem;
  logic                       rd_ptr, wr_ptr;
  logic [1:0]                 cnt;
  logic                       ovr;

  // N samples of DATA_W bits sum to at most 2^ACC_W - N, so neither the
  // sum nor the half-LSB rounding bias can wrap the accumulator.
  assign sum  = acc + ACC_W'(bus.in_data);
`ifdef LPF_DECIM_ROUND_EN
  assign sum_r = sum + (ACC_W'(1) << (LOG2_DECIM - 1));
`else
  assign sum_r = sum;
`endif
  assign avg  = DATA_W'(sum_r >> LOG2_DECIM);

  assign last    = &phase;
  assign push    = bus.in_valid && last;
  assign full    = cnt[1];
  assign pop     = bus.out_valid && bus.out_ready;
  assign do_push = push && (!full || pop);
  // When full, rd_ptr+2 aliases rd_ptr: the slot being popped is refilled.
  assign wr_ptr  = rd_ptr ^ cnt[0];

  assign bus.out_valid = |cnt;
  assign bus.out_data  = (|cnt) ? mem[rd_ptr] : '0;
  assign bus.overrun   = ovr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc   <= '0;
      phase <= '0;
    end else if (clr) begin
      acc   <= '0;
      phase <= '0;
    end else if (bus.in_valid) begin
      acc   <= last ? '0 : sum;
      phase <= phase + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem    <= '0;
      rd_ptr <= 1'b0;
      cnt    <= '0;
      ovr    <= 1'b0;
    end else if (clr) begin
      rd_ptr <= 1'b0;
      cnt    <= '0;
      ovr    <= 1'b0;
    end else begin
      if (do_push)
        mem[wr_ptr] <= avg;
      if (pop)
        rd_ptr <= ~rd_ptr;
      if (push && full && !pop)
        ovr <= 1'b1;
      cnt <= cnt + {1'b0, do_push} - {1'b0, pop};
    end
  end
endmodule
